// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter
// Description : Serializes cache line fills/writebacks into 64-bit memory bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adapter #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    input  logic                 bmem_ready,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_rvalid,
    input  logic [BEAT_BITS-1:0] bmem_rdata
);

    localparam int c_BEATS = LINE_BITS / BEAT_BITS;
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_OFF_W = $clog2(LINE_BITS / 8);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_BEAT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                             r_state, w_state_next;
    logic [c_CNT_W-1:0]                 r_cnt, w_cnt_next;
    logic [c_BEATS-1:0][BEAT_BITS-1:0]  r_buf, w_buf_next, w_wline;
    logic [31:0]                        r_addr, w_addr_next, w_aligned;
    logic [LINE_BITS-1:0]               r_rdata, w_rdata_next;
    logic                               w_unused_addr;

    assign w_wline       = dfp_wdata;
    assign w_aligned     = {dfp_addr[31:c_OFF_W], {c_OFF_W{1'b0}}};
    assign w_unused_addr = ^dfp_addr[c_OFF_W-1:0];
    assign dfp_rdata     = r_rdata;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_buf_next   = r_buf;
        w_addr_next  = r_addr;
        w_rdata_next = r_rdata;
        bmem_read    = 1'b0;
        bmem_write   = 1'b0;
        bmem_addr    = '0;
        bmem_wdata   = '0;
        dfp_resp     = 1'b0;

        case (r_state)
            IDLE: begin
                // Beat 0 goes out in the accept cycle straight from the request bus.
                if (dfp_write && bmem_ready) begin
                    bmem_write   = 1'b1;
                    bmem_addr    = w_aligned;
                    bmem_wdata   = w_wline[0];
                    w_buf_next   = w_wline;
                    w_addr_next  = w_aligned;
                    w_cnt_next   = c_ONE;
                    w_state_next = WR_BEAT;
                end else if (dfp_read && bmem_ready) begin
                    bmem_read    = 1'b1;
                    bmem_addr    = w_aligned;
                    w_addr_next  = w_aligned;
                    w_cnt_next   = '0;
                    w_state_next = RD_WAIT;
                end
            end
            WR_BEAT: begin
                bmem_write = 1'b1;
                bmem_addr  = r_addr;
                bmem_wdata = r_buf[r_cnt];
                w_cnt_next = r_cnt + c_ONE;
                if (r_cnt == c_LAST) begin
                    w_state_next = RESP;
                end
            end
            RD_WAIT: begin
                if (bmem_rvalid) begin
                    w_buf_next[r_cnt] = bmem_rdata;
                    w_cnt_next        = r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        w_rdata_next = w_buf_next;
                        w_state_next = RESP;
                    end
                end
            end
            RESP: begin
                dfp_resp     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase

        // Nothing leaves the block while reset is asserted.
        if (rst) begin
            bmem_read  = 1'b0;
            bmem_write = 1'b0;
            bmem_addr  = '0;
            bmem_wdata = '0;
            dfp_resp   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_addr  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_buf   <= w_buf_next;
            r_addr  <= w_addr_next;
            r_rdata <= w_rdata_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_adapter
// Description : Self-checking bench: vector table, corner sequences, random fills/writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic         bmem_ready;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_rvalid;
    logic [63:0]  bmem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] last_fill;

    typedef struct {
        bit           wr;
        bit           both;
        logic [31:0]  addr;
        logic [255:0] line;
        int           rdy_dly;
        int           gap;
        bit           stray;
        bit           chain;
        logic [31:0]  exp_addr;
        logic [255:0] exp_rdata;
    } vec_t;

    cacheline_adapter #(.LINE_BITS(256), .BEAT_BITS(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_ready  (bmem_ready),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_rvalid (bmem_rvalid),
        .bmem_rdata  (bmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_outputs", {bmem_read, bmem_write, dfp_resp, bmem_addr, bmem_wdata}, '0);
            next_cycle();
        end
    endtask

    function automatic vec_t mk(bit wr, bit both, logic [31:0] addr, logic [255:0] line,
                                int rdy, int gap, bit stray, bit chain,
                                logic [31:0] ea, logic [255:0] er);
        vec_t v;
        v.wr = wr; v.both = both; v.addr = addr; v.line = line;
        v.rdy_dly = rdy; v.gap = gap; v.stray = stray; v.chain = chain;
        v.exp_addr = ea; v.exp_rdata = er;
        return v;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after dfp_resp.
    task automatic run_xfer(input vec_t v);
        dfp_addr   = v.addr;
        dfp_write  = v.wr;
        dfp_read   = !v.wr || v.both;
        dfp_wdata  = v.wr ? v.line : {8{32'hCAFE_F00D}};
        bmem_ready = 1'b0;
        for (int i = 0; i < v.rdy_dly; i++) begin
            @(negedge clk);
            chk("stall_no_request", {bmem_read, bmem_write, dfp_resp}, '0);
            next_cycle();
        end
        bmem_ready = 1'b1;
        @(negedge clk);
        chk("accept_strobes", {bmem_read, bmem_write, dfp_resp}, v.wr ? 3'b010 : 3'b100);
        chk("accept_addr", bmem_addr, v.exp_addr);
        if (v.wr) chk("write_beat0", bmem_wdata, v.line[63:0]);
        next_cycle();
        dfp_addr  = $urandom;
        dfp_wdata = {8{$urandom}};
        if (v.wr) begin
            for (int b = 1; b < 4; b++) begin
                bmem_rvalid = v.stray;
                bmem_rdata  = {$urandom, $urandom};
                @(negedge clk);
                chk("write_strobes", {bmem_read, bmem_write, dfp_resp}, 3'b010);
                chk("write_addr", bmem_addr, v.exp_addr);
                chk("write_beat", bmem_wdata, v.line[b*64 +: 64]);
                next_cycle();
            end
            bmem_rvalid = 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (b > 0) begin
                    for (int g = 0; g < v.gap; g++) begin
                        bmem_rvalid = 1'b0;
                        @(negedge clk);
                        chk("read_gap_quiet", {bmem_read, bmem_write, dfp_resp}, '0);
                        next_cycle();
                    end
                end
                bmem_rvalid = 1'b1;
                bmem_rdata  = v.line[b*64 +: 64];
                @(negedge clk);
                chk("read_beat_quiet", {bmem_read, bmem_write, dfp_resp, bmem_addr}, '0);
                next_cycle();
            end
            bmem_rvalid = 1'b0;
        end
        @(negedge clk);
        chk("resp_pulse", {bmem_read, bmem_write, dfp_resp}, 3'b001);
        chk("resp_rdata", dfp_rdata, v.exp_rdata);
        next_cycle();
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
    endtask

    vec_t tbl[6];
    vec_t rv;
    logic [255:0] l0, l1, l2, l3, l4, l5;

    initial begin
        rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = '0;
        last_fill = '0;

        l0 = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        l1 = {{8{8'hA3}}, {8{8'hA2}}, {8{8'hA1}}, {8{8'hA0}}};
        l2 = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
        l3 = {64'h0F0F_0F0F_F0F0_F0F0, 64'h1234_5678_9ABC_DEF0, 64'h5555_AAAA_5555_AAAA, 64'h0000_0000_FFFF_FFFF};
        l4 = {64'h8000_0000_0000_0004, 64'h0000_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
        l5 = {64'hB5B5_B5B5_B5B5_B5B5, 64'hB4B4_B4B4_B4B4_B4B4, 64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2};

        //          wr both addr          line rdy gap stray chain exp_addr      exp_rdata
        tbl[0] = mk(0, 0, 32'h0000_1234, l0, 0, 0, 0, 0, 32'h0000_1220, l0);
        tbl[1] = mk(1, 0, 32'h8000_00E0, l1, 0, 0, 0, 0, 32'h8000_00E0, l0);
        tbl[2] = mk(0, 0, 32'h0000_5A7F, l2, 3, 2, 0, 0, 32'h0000_5A60, l2);
        tbl[3] = mk(1, 0, 32'h0000_00FF, l3, 0, 0, 1, 0, 32'h0000_00E0, l2);
        tbl[4] = mk(0, 0, 32'hFFFF_FFFF, l4, 0, 1, 0, 1, 32'hFFFF_FFE0, l4);
        tbl[5] = mk(1, 1, 32'h4000_0010, l5, 1, 0, 0, 0, 32'h4000_0000, l4);

        next_cycle();
        @(negedge clk);
        chk("reset_strobes", {bmem_read, bmem_write, dfp_resp, bmem_addr, bmem_wdata}, '0);
        chk("reset_rdata", dfp_rdata, '0);
        next_cycle();
        rst = 1'b0;
        idle_cycles(2);

        for (int i = 0; i < 6; i++) begin
            if (!tbl[i].chain) idle_cycles(1);
            run_xfer(tbl[i]);
            if (!tbl[i].wr) last_fill = tbl[i].line;
        end
        idle_cycles(1);

        // Reset after two read beats: the partial fill must vanish without a response.
        dfp_read = 1'b1; dfp_addr = 32'h0000_3000; bmem_ready = 1'b1;
        @(negedge clk);
        chk("rst_seq_accept", {bmem_read, bmem_addr}, {1'b1, 32'h0000_3000});
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            bmem_rvalid = 1'b1; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0 + 64'(b);
            @(negedge clk);
            chk("rst_seq_beat_quiet", {bmem_read, bmem_write, dfp_resp}, '0);
            next_cycle();
        end
        bmem_rvalid = 1'b0; rst = 1'b1; dfp_read = 1'b0;
        @(negedge clk);
        chk("rst_seq_no_resp", dfp_resp, '0);
        next_cycle();
        rst = 1'b0;
        last_fill = '0;
        for (int i = 0; i < 3; i++) begin
            bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
            @(negedge clk);
            chk("post_rst_quiet", {bmem_read, bmem_write, dfp_resp}, '0);
            next_cycle();
        end
        bmem_rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_rdata", dfp_rdata, last_fill);
        next_cycle();
        run_xfer(mk(0, 0, 32'h0000_3008, l3, 0, 0, 0, 0, 32'h0000_3000, l3));
        last_fill = l3;
        idle_cycles(1);

        // Random traffic against the line-level model.
        for (int n = 0; n < 24; n++) begin
            rv.wr      = 1'($urandom_range(0, 1));
            rv.both    = rv.wr & 1'($urandom_range(0, 1));
            rv.addr    = $urandom;
            for (int k = 0; k < 8; k++) rv.line[k*32 +: 32] = $urandom;
            rv.rdy_dly = int'($urandom_range(0, 2));
            rv.gap     = int'($urandom_range(0, 2));
            rv.stray   = 1'($urandom_range(0, 1));
            rv.chain   = 1'($urandom_range(0, 1));
            rv.exp_addr  = rv.addr & ~32'h1F;
            rv.exp_rdata = rv.wr ? last_fill : rv.line;
            if (!rv.chain) idle_cycles(1);
            run_xfer(rv);
            if (!rv.wr) last_fill = rv.line;
        end
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
